// File: rtl/pwr_amp_sequencer_if.sv
// Host/pin bundle for the motor-power sequencer: command strobes, relay and
// supply feedback, and the registered drive/status outputs.
interface pwr_amp_sequencer_if #(
  parameter int NUM_AXES = 4
);
  logic                tick;
  logic                start;
  logic [NUM_AXES-1:0] axis_mask;
  logic                stop;
  logic                clr_err;
  logic                trip;
  logic                relay_fb_n;
  logic                mv_good;
  logic                relay_on;
  logic                pwr_enable;
  logic [NUM_AXES-1:0] amp_enable;
  logic [2:0]          state;
  logic                busy;
  logic                err;
  logic [1:0]          err_code;

  // Host / board side: drives commands and feedback, observes outputs.
  modport master (
    output tick, start, axis_mask, stop, clr_err, trip, relay_fb_n, mv_good,
    input  relay_on, pwr_enable, amp_enable, state, busy, err, err_code
  );

  // Sequencer side.
  modport slave (
    input  tick, start, axis_mask, stop, clr_err, trip, relay_fb_n, mv_good,
    output relay_on, pwr_enable, amp_enable, state, busy, err, err_code
  );
endinterface

// File: rtl/pwr_amp_sequencer.sv
// Motor-power sequencer: closes the safety relay, enables the motor supply,
// waits for mv_good to settle, then enables amplifiers one axis at a time.
// Any trip drops every drive output on the same edge and latches an error
// code until the host clears it.
module pwr_amp_sequencer #(
  parameter int NUM_AXES      = 4,
  parameter int RELAY_TIMEOUT = 192,
  parameter int MV_TIMEOUT    = 3840,
  parameter int SETTLE_TICKS  = 7680,
  parameter int STAGGER_TICKS = 96
) (
  input  logic               sysclk,
  input  logic               reset,
  pwr_amp_sequencer_if.slave bus
);

  localparam int IDX_W = (NUM_AXES > 1) ? $clog2(NUM_AXES) : 1;
  localparam logic [15:0]      C_RELAY_TO = 16'(RELAY_TIMEOUT);
  localparam logic [15:0]      C_MV_TO    = 16'(MV_TIMEOUT);
  localparam logic [15:0]      C_SETTLE   = 16'(SETTLE_TICKS);
  localparam logic [15:0]      C_STAGGER  = 16'(STAGGER_TICKS);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_AXES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RELAY    = 3'd1,
    S_POWER    = 3'd2,
    S_SETTLE   = 3'd3,
    S_ENABLE   = 3'd4,
    S_RUN      = 3'd5,
    S_SHUTDOWN = 3'd6,
    S_FAULT    = 3'd7
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [15:0]         r_cnt;
  logic [IDX_W-1:0]    r_idx, w_idx_nxt;
  logic [NUM_AXES-1:0] r_mask, w_mask_nxt;
  logic [NUM_AXES-1:0] r_amp, w_amp_nxt;
  logic                r_relay, w_relay_nxt;
  logic                r_pwr, w_pwr_nxt;
  logic [1:0]          r_code, w_code_nxt;
  logic                r_busy, r_err;
  logic                w_step;
  logic                w_mv_lost;
  logic                w_timeout;
  logic [1:0]          w_to_code;

  // Next-state and next-output decode; trip beats mv loss beats timeout beats stop.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_mask_nxt  = r_mask;
    w_amp_nxt   = r_amp;
    w_relay_nxt = r_relay;
    w_pwr_nxt   = r_pwr;
    w_code_nxt  = r_code;
    w_step      = 1'b0;
    w_mv_lost   = 1'b0;
    w_timeout   = 1'b0;
    w_to_code   = 2'd0;
    case (r_state)
      S_IDLE: begin
        if (bus.start && (bus.axis_mask != '0)) begin
          w_mask_nxt  = bus.axis_mask;
          w_relay_nxt = 1'b1;
          w_state_nxt = S_RELAY;
        end
      end
      S_FAULT: begin
        if (bus.clr_err) w_state_nxt = S_IDLE;
      end
      default: begin
        w_mv_lost = ((r_state == S_SETTLE) || (r_state == S_ENABLE) ||
                     (r_state == S_RUN)) && !bus.mv_good;
        if ((r_state == S_RELAY) && (r_cnt >= C_RELAY_TO)) begin
          w_timeout = 1'b1;
          w_to_code = 2'd1;
        end
        if ((r_state == S_POWER) && (r_cnt >= C_MV_TO)) begin
          w_timeout = 1'b1;
          w_to_code = 2'd2;
        end
        if (bus.trip || w_mv_lost || w_timeout) begin
          w_state_nxt = S_FAULT;
          w_relay_nxt = 1'b0;
          w_pwr_nxt   = 1'b0;
          w_amp_nxt   = '0;
          w_code_nxt  = bus.trip ? 2'd0 : (w_mv_lost ? 2'd3 : w_to_code);
        end else if (bus.stop && (r_state != S_SHUTDOWN)) begin
          // Amps drop first; supply and relay follow after the stagger delay.
          w_state_nxt = S_SHUTDOWN;
          w_amp_nxt   = '0;
        end else begin
          case (r_state)
            S_RELAY: begin
              if (!bus.relay_fb_n) begin
                w_pwr_nxt   = 1'b1;
                w_state_nxt = S_POWER;
              end
            end
            S_POWER: begin
              if (bus.mv_good) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
              if (r_cnt >= C_SETTLE) begin
                w_idx_nxt   = '0;
                w_state_nxt = S_ENABLE;
              end
            end
            S_ENABLE: begin
              // Enabling an axis restarts the stagger wait; masked-off axes pass in one cycle.
              if (r_mask[r_idx] && !r_amp[r_idx]) begin
                w_amp_nxt[r_idx] = 1'b1;
                w_step           = 1'b1;
              end else if (!r_mask[r_idx] || (r_cnt >= C_STAGGER)) begin
                w_step = 1'b1;
                if (r_idx == C_LAST_IDX) w_state_nxt = S_RUN;
                else                     w_idx_nxt   = r_idx + 1'b1;
              end
            end
            S_SHUTDOWN: begin
              if (r_cnt >= C_STAGGER) begin
                w_pwr_nxt   = 1'b0;
                w_relay_nxt = 1'b0;
                w_state_nxt = S_IDLE;
              end
            end
            default: ;
          endcase
        end
      end
    endcase
  end

  // State, tick counter and registered outputs.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_mask  <= '0;
      r_amp   <= '0;
      r_relay <= 1'b0;
      r_pwr   <= 1'b0;
      r_code  <= 2'd0;
      r_busy  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if ((w_state_nxt != r_state) || w_step) r_cnt <= '0;
      else if (bus.tick)                      r_cnt <= r_cnt + 16'd1;
      r_idx   <= w_idx_nxt;
      r_mask  <= w_mask_nxt;
      r_amp   <= w_amp_nxt;
      r_relay <= w_relay_nxt;
      r_pwr   <= w_pwr_nxt;
      r_code  <= w_code_nxt;
      r_busy  <= (w_state_nxt inside {S_RELAY, S_POWER, S_SETTLE, S_ENABLE, S_SHUTDOWN});
      r_err   <= (w_state_nxt == S_FAULT);
    end
  end

  assign bus.relay_on   = r_relay;
  assign bus.pwr_enable = r_pwr;
  assign bus.amp_enable = r_amp;
  assign bus.state      = r_state;
  assign bus.busy       = r_busy;
  assign bus.err        = r_err;
  assign bus.err_code   = r_code;

endmodule
